// File: rtl/ramb16_s2_arb.sv
// Two-requester round-robin front end for an 8K x 2 block RAM, with an optional
// clear engine that fills the whole array after reset before serving anyone.
module ramb16_s2_arb #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [1:0] CLR_VAL        = 2'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [12:0] ADDR0,
    input  logic [12:0] ADDR1,
    input  logic [1:0]  DI0,
    input  logic [1:0]  DI1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        RVLD0,
    output logic        RVLD1,
    output logic [1:0]  DO0,
    output logic [1:0]  DO1,
    output logic        BUSY,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic        RAM_SSR,
    output logic [12:0] RAM_ADDR,
    output logic [1:0]  RAM_DI,
    input  logic [1:0]  RAM_DO
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] clr_cnt_q, clr_cnt_d;
    logic        ptr_q, ptr_d;
    logic        rvld0_q, rvld0_d;
    logic        rvld1_q, rvld1_d;
    logic [1:0]  do0_q, do0_d;
    logic [1:0]  do1_q, do1_d;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_cnt_q <= '0;
            ptr_q     <= 1'b0;
            rvld0_q   <= 1'b0;
            rvld1_q   <= 1'b0;
            do0_q     <= '0;
            do1_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            rvld0_q   <= rvld0_d;
            rvld1_q   <= rvld1_d;
            do0_q     <= do0_d;
            do1_q     <= do1_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        rvld0_d   = GNT0 & ~WE0;
        rvld1_d   = GNT1 & ~WE1;
        do0_d     = RVLD0 ? RAM_DO : do0_q;
        do1_d     = RVLD1 ? RAM_DO : do1_q;

        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 13'd1;
            if (clr_cnt_q == '1) begin
                state_d = S_RUN;
            end
        end

        // Pointer always moves to the requester that lost (or was absent)
        if (GNT0) begin
            ptr_d = 1'b1;
        end else if (GNT1) begin
            ptr_d = 1'b0;
        end
    end

    // Output logic; the reset cycle issues no grant, no RAM access and no read-valid
    always_comb begin
        GNT0     = 1'b0;
        GNT1     = 1'b0;
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_SSR  = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        BUSY     = (state_q == S_CLEAR);

        if (!RST) begin
            if (state_q == S_CLEAR) begin
                RAM_EN   = 1'b1;
                RAM_WE   = 1'b1;
                RAM_ADDR = clr_cnt_q;
                RAM_DI   = CLR_VAL;
            end else if (REQ0 && (!REQ1 || !ptr_q)) begin
                GNT0     = 1'b1;
                RAM_EN   = 1'b1;
                RAM_WE   = WE0;
                RAM_ADDR = ADDR0;
                RAM_DI   = DI0;
            end else if (REQ1) begin
                GNT1     = 1'b1;
                RAM_EN   = 1'b1;
                RAM_WE   = WE1;
                RAM_ADDR = ADDR1;
                RAM_DI   = DI1;
            end
        end

        RVLD0 = rvld0_q & ~RST;
        RVLD1 = rvld1_q & ~RST;
        DO0   = RVLD0 ? RAM_DO : do0_q;
        DO1   = RVLD1 ? RAM_DO : do1_q;
    end

endmodule

// File: tb/tb_ramb16_s2_arb.sv
// Bench for ramb16_s2_arb: behavioural RAM behind the DUT, reference memory and
// round-robin model driven from randomized requester traffic.
module tb_ramb16_s2_arb;

    localparam logic [1:0] CLR = 2'h3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [12:0] ADDR0 = '0, ADDR1 = '0;
    logic [1:0]  DI0 = '0, DI1 = '0;
    logic        GNT0, GNT1, RVLD0, RVLD1, BUSY, RAM_EN, RAM_WE, RAM_SSR;
    logic [1:0]  DO0, DO1, RAM_DI;
    logic [12:0] RAM_ADDR;
    logic [1:0]  RAM_DO = '0;

    logic        rst_b = 1'b1, req1_b = 1'b1, we1_b = 1'b1;
    logic [12:0] addr1_b = 13'h0042;
    logic [1:0]  di1_b = 2'h1;
    logic        req0_b = 1'b0, we0_b = 1'b0;
    logic [12:0] addr0_b = '0;
    logic [1:0]  di0_b = '0, ram_do_b = '0;
    logic        gnt0_b, gnt1_b, rvld0_b, rvld1_b, busy_b, ram_en_b, ram_we_b, ram_ssr_b;
    logic [1:0]  do0_b, do1_b, ram_di_b;
    logic [12:0] ram_addr_b;

    int checks = 0;
    int errors = 0;

    logic [1:0] mem     [8192];
    logic [1:0] ref_mem [8192];
    logic       ptr_m;
    logic [1:0] last_do0, last_do1;

    ramb16_s2_arb #(.CLEAR_ON_RESET(1'b1), .CLR_VAL(CLR)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .DI0(DI0), .DI1(DI1), .GNT0(GNT0), .GNT1(GNT1),
        .RVLD0(RVLD0), .RVLD1(RVLD1), .DO0(DO0), .DO1(DO1), .BUSY(BUSY),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR), .RAM_ADDR(RAM_ADDR),
        .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    ramb16_s2_arb #(.CLEAR_ON_RESET(1'b0), .CLR_VAL(2'h0)) dut_b (
        .CLK(CLK), .RST(rst_b), .REQ0(req0_b), .REQ1(req1_b), .WE0(we0_b), .WE1(we1_b),
        .ADDR0(addr0_b), .ADDR1(addr1_b), .DI0(di0_b), .DI1(di1_b), .GNT0(gnt0_b), .GNT1(gnt1_b),
        .RVLD0(rvld0_b), .RVLD1(rvld1_b), .DO0(do0_b), .DO1(do1_b), .BUSY(busy_b),
        .RAM_EN(ram_en_b), .RAM_WE(ram_we_b), .RAM_SSR(ram_ssr_b), .RAM_ADDR(ram_addr_b),
        .RAM_DI(ram_di_b), .RAM_DO(ram_do_b)
    );

    always #5 CLK = ~CLK;

    // Block RAM behind the main DUT: synchronous write, registered read
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DI;
            else        RAM_DO <= mem[RAM_ADDR];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_no_clear();
        tick();
        #1;
        checks++;
        if (gnt1_b !== 1'b0 || ram_en_b !== 1'b0) begin
            errors++;
            $display("FAIL noclear_in_reset: gnt1=%b ram_en=%b required 0 0", gnt1_b, ram_en_b);
        end
        tick();
        rst_b = 1'b0;
        #1;
        checks++;
        if (busy_b !== 1'b0 || gnt1_b !== 1'b1 || gnt0_b !== 1'b0) begin
            errors++;
            $display("FAIL noclear_first_cycle: busy=%b gnt1=%b gnt0=%b required 0 1 0", busy_b, gnt1_b, gnt0_b);
        end
        checks++;
        if (ram_en_b !== 1'b1 || ram_we_b !== 1'b1 || ram_addr_b !== 13'h0042 || ram_di_b !== 2'h1 || ram_ssr_b !== 1'b0) begin
            errors++;
            $display("FAIL noclear_ram_port: en=%b we=%b addr=%h di=%h ssr=%b required 1 1 0042 1 0",
                     ram_en_b, ram_we_b, ram_addr_b, ram_di_b, ram_ssr_b);
        end
        checks++;
        if (rvld0_b !== 1'b0 || rvld1_b !== 1'b0 || do0_b !== 2'h0 || do1_b !== 2'h0) begin
            errors++;
            $display("FAIL noclear_read_side: rvld=%b%b do0=%h do1=%h required 00 0 0", rvld0_b, rvld1_b, do0_b, do1_b);
        end
        req1_b = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (GNT0 !== 1'b0 || GNT1 !== 1'b0 || RAM_EN !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_quiet: gnt=%b%b ram_en=%b required 00 0", GNT0, GNT1, RAM_EN);
        end
        REQ0  = 1'b1;
        WE0   = 1'b0;
        ADDR0 = 13'h1ABC;
        RST   = 1'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = CLR;
        ptr_m = 1'b0;
        last_do0 = '0;
        last_do1 = '0;
        #1;
        checks++;
        if (RVLD0 !== 1'b0 || RVLD1 !== 1'b0 || DO0 !== 2'h0 || DO1 !== 2'h0 || BUSY !== 1'b1 || RAM_SSR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rvld=%b%b do0=%h do1=%h busy=%b ssr=%b required 00 0 0 1 0",
                     RVLD0, RVLD1, DO0, DO1, BUSY, RAM_SSR);
        end
    endtask

    task automatic test_clear();
        for (int unsigned i = 0; i < 8192; i++) begin
            if (i != 0) begin
                tick();
                #1;
            end
            checks++;
            if (BUSY !== 1'b1 || RAM_EN !== 1'b1 || RAM_WE !== 1'b1 || RAM_ADDR !== 13'(i) ||
                RAM_DI !== CLR || GNT0 !== 1'b0 || GNT1 !== 1'b0) begin
                errors++;
                $display("FAIL clear_step: cycle %0d busy=%b en=%b we=%b addr=%h di=%h gnt0=%b required 1 1 1 %h %h 0",
                         i, BUSY, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, GNT0, 13'(i), CLR);
            end
        end
        tick();
        #1;
        checks++;
        if (BUSY !== 1'b0 || GNT0 !== 1'b1 || RAM_WE !== 1'b0 || RAM_ADDR !== 13'h1ABC) begin
            errors++;
            $display("FAIL clear_done_grant: busy=%b gnt0=%b we=%b addr=%h required 0 1 0 1abc", BUSY, GNT0, RAM_WE, RAM_ADDR);
        end
        ptr_m = 1'b1;
        tick();
        REQ0 = 1'b0;
        #1;
        checks++;
        if (RVLD0 !== 1'b1 || DO0 !== ref_mem[13'h1ABC] || RVLD1 !== 1'b0) begin
            errors++;
            $display("FAIL clear_readback: rvld0=%b do0=%h rvld1=%b required 1 %h 0", RVLD0, DO0, RVLD1, ref_mem[13'h1ABC]);
        end
        last_do0 = ref_mem[13'h1ABC];
    endtask

    task automatic test_write_read();
        tick();
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 13'h0005; DI0 = 2'h2;
        #1;
        checks++;
        if (GNT0 !== 1'b1 || GNT1 !== 1'b0 || RAM_WE !== 1'b1 || RAM_ADDR !== 13'h0005 || RAM_DI !== 2'h2) begin
            errors++;
            $display("FAIL wr_grant: gnt=%b%b we=%b addr=%h di=%h required 10 1 0005 2", GNT0, GNT1, RAM_WE, RAM_ADDR, RAM_DI);
        end
        checks++;
        if (RVLD0 !== 1'b0 || DO0 !== last_do0) begin
            errors++;
            $display("FAIL wr_do_hold: rvld0=%b do0=%h required 0 %h", RVLD0, DO0, last_do0);
        end
        ref_mem[5] = 2'h2;
        tick();
        WE0 = 1'b0;
        #1;
        checks++;
        if (GNT0 !== 1'b1 || RVLD0 !== 1'b0 || RVLD1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant_no_wr_pulse: gnt0=%b rvld=%b%b required 1 00", GNT0, RVLD0, RVLD1);
        end
        tick();
        REQ0 = 1'b0;
        #1;
        checks++;
        if (RVLD0 !== 1'b1 || DO0 !== 2'h2 || RVLD1 !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: rvld0=%b do0=%h rvld1=%b required 1 2 0", RVLD0, DO0, RVLD1);
        end
        tick();
        #1;
        checks++;
        if (RVLD0 !== 1'b0 || DO0 !== 2'h2 || RAM_EN !== 1'b0 || RAM_WE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: rvld0=%b do0=%h en=%b we=%b busy=%b required 0 2 0 0 0", RVLD0, DO0, RAM_EN, RAM_WE, BUSY);
        end
        last_do0 = 2'h2;
        ptr_m = 1'b1;
    endtask

    task automatic test_random();
        bit act0 = 0, act1 = 0, pend0 = 0, pend1 = 0, e0, e1;
        logic w0 = 0, w1 = 0;
        logic [12:0] a0 = '0, a1 = '0;
        logic [1:0] d0 = '0, d1 = '0, pdat0 = '0, pdat1 = '0;
        int wait0 = 0, wait1 = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!act0 && $urandom_range(0, 1) == 1) begin
                act0 = 1; w0 = 1'($urandom_range(0, 1)); a0 = 13'($urandom_range(0, 31)); d0 = 2'($urandom);
            end
            if (!act1 && $urandom_range(0, 1) == 1) begin
                act1 = 1; w1 = 1'($urandom_range(0, 1)); a1 = 13'($urandom_range(0, 31)); d1 = 2'($urandom);
            end
            REQ0 = act0; WE0 = w0; ADDR0 = a0; DI0 = d0;
            REQ1 = act1; WE1 = w1; ADDR1 = a1; DI1 = d1;
            #1;
            e0 = act0 && (!act1 || ptr_m == 1'b0);
            e1 = act1 && !e0;
            checks++;
            if (GNT0 !== e0 || GNT1 !== e1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL rand_grant: cycle %0d gnt=%b%b busy=%b required %b%b 0", c, GNT0, GNT1, BUSY, e0, e1);
            end
            checks++;
            if (RVLD0 !== pend0 || RVLD1 !== pend1) begin
                errors++;
                $display("FAIL rand_rvld: cycle %0d rvld=%b%b required %b%b", c, RVLD0, RVLD1, pend0, pend1);
            end
            if (pend0) last_do0 = pdat0;
            if (pend1) last_do1 = pdat1;
            checks++;
            if (DO0 !== last_do0 || DO1 !== last_do1) begin
                errors++;
                $display("FAIL rand_do: cycle %0d do0=%h do1=%h required %h %h", c, DO0, DO1, last_do0, last_do1);
            end
            checks++;
            if (e0 || e1) begin
                if (RAM_EN !== 1'b1 || RAM_WE !== (e0 ? w0 : w1) || RAM_ADDR !== (e0 ? a0 : a1) ||
                    (RAM_WE === 1'b1 && RAM_DI !== (e0 ? d0 : d1))) begin
                    errors++;
                    $display("FAIL rand_ram_port: cycle %0d en=%b we=%b addr=%h di=%h required 1 %b %h %h",
                             c, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, e0 ? w0 : w1, e0 ? a0 : a1, e0 ? d0 : d1);
                end
            end else if (RAM_EN !== 1'b0 || RAM_WE !== 1'b0) begin
                errors++;
                $display("FAIL rand_ram_idle: cycle %0d en=%b we=%b required 0 0", c, RAM_EN, RAM_WE);
            end
            wait0 = (act0 && !e0) ? wait0 + 1 : 0;
            wait1 = (act1 && !e1) ? wait1 + 1 : 0;
            checks++;
            if (wait0 > 1 || wait1 > 1) begin
                errors++;
                $display("FAIL rand_starve: cycle %0d waits %0d %0d required <= 1", c, wait0, wait1);
            end
            pend0 = e0 && !w0;
            pend1 = e1 && !w1;
            pdat0 = ref_mem[a0];
            pdat1 = ref_mem[a1];
            if (e0 && w0) ref_mem[a0] = d0;
            if (e1 && w1) ref_mem[a1] = d1;
            if (e0) begin act0 = 0; ptr_m = 1'b1; end
            if (e1) begin act1 = 0; ptr_m = 1'b0; end
        end
        tick();
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        #1;
        if (pend0) last_do0 = pdat0;
        if (pend1) last_do1 = pdat1;
        checks++;
        if (RVLD0 !== pend0 || RVLD1 !== pend1 || DO0 !== last_do0 || DO1 !== last_do1) begin
            errors++;
            $display("FAIL rand_drain: rvld=%b%b do=%h/%h required %b%b %h/%h", RVLD0, RVLD1, DO0, DO1, pend0, pend1, last_do0, last_do1);
        end
    endtask

    task automatic test_contention();
        logic [12:0] ta0 [2];
        logic [12:0] ta1 [2];
        logic [1:0] exp_d;
        int n0, n1, g;
        tick();
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 13'h0100; DI1 = 2'h1;
        #1;
        checks++;
        if (GNT1 !== 1'b1 || GNT0 !== 1'b0) begin
            errors++;
            $display("FAIL cont_setup: gnt=%b%b required 01", GNT0, GNT1);
        end
        ref_mem[13'h0100] = 2'h1;
        ptr_m = 1'b0;
        ta0[0] = 13'($urandom_range(0, 31)); ta0[1] = 13'h0100;
        ta1[0] = 13'($urandom_range(0, 31)); ta1[1] = 13'h0005;
        for (int c = 0; c < 5; c++) begin
            tick();
            n0 = (c + 1) / 2;
            n1 = c / 2;
            REQ0 = (n0 < 2); WE0 = 1'b0; ADDR0 = ta0[(n0 < 2) ? n0 : 1];
            REQ1 = (n1 < 2); WE1 = 1'b0; ADDR1 = ta1[(n1 < 2) ? n1 : 1];
            #1;
            checks++;
            if (GNT0 !== (c < 4 && c % 2 == 0) || GNT1 !== (c < 4 && c % 2 == 1)) begin
                errors++;
                $display("FAIL cont_grant: step %0d gnt=%b%b required %b%b", c, GNT0, GNT1, c < 4 && c % 2 == 0, c < 4 && c % 2 == 1);
            end
            checks++;
            if (c == 0) begin
                if (RVLD0 !== 1'b0 || RVLD1 !== 1'b0) begin
                    errors++;
                    $display("FAIL cont_rvld0: rvld=%b%b required 00", RVLD0, RVLD1);
                end
            end else begin
                g = (c - 1) % 2;
                exp_d = (g == 0) ? ref_mem[ta0[(c - 1) / 2]] : ref_mem[ta1[(c - 1) / 2]];
                if (g == 0) last_do0 = exp_d;
                else        last_do1 = exp_d;
                if (RVLD0 !== (g == 0) || RVLD1 !== (g == 1) || DO0 !== last_do0 || DO1 !== last_do1) begin
                    errors++;
                    $display("FAIL cont_rvld: step %0d rvld=%b%b do=%h/%h required %b%b %h/%h",
                             c, RVLD0, RVLD1, DO0, DO1, g == 0, g == 1, last_do0, last_do1);
                end
            end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        ptr_m = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        tick();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 13'h0005;
        #1;
        checks++;
        if (GNT0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_read: gnt0=%b required 1", GNT0);
        end
        tick();
        RST = 1'b1; WE0 = 1'b1; ADDR0 = 13'h0007; DI0 = 2'h1;
        #1;
        checks++;
        if (RVLD0 !== 1'b0 || GNT0 !== 1'b0 || RAM_EN !== 1'b0 || RAM_WE !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_drop: rvld0=%b gnt0=%b en=%b we=%b required 0 0 0 0", RVLD0, GNT0, RAM_EN, RAM_WE);
        end
        tick();
        RST = 1'b0;
        REQ0 = 1'b0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = CLR;
        ptr_m = 1'b0;
        last_do0 = '0;
        last_do1 = '0;
        #1;
        checks++;
        if (DO0 !== 2'h0 || DO1 !== 2'h0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_state: do0=%h do1=%h busy=%b required 0 0 1", DO0, DO1, BUSY);
        end
        for (int unsigned i = 0; i < 13'h0800; i++) begin
            if (i != 0) begin
                tick();
                #1;
            end
            checks++;
            if (RAM_ADDR !== 13'(i) || RAM_WE !== 1'b1 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL mid_clear_step: cycle %0d addr=%h we=%b busy=%b required %h 1 1", i, RAM_ADDR, RAM_WE, BUSY, 13'(i));
            end
        end
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_rst_busy: busy=%b required 1", BUSY);
        end
        tick();
        RST = 1'b0;
        #1;
        for (int unsigned i = 0; i < 8192; i++) begin
            if (i != 0) begin
                tick();
                #1;
            end
            checks++;
            if (RAM_ADDR !== 13'(i) || RAM_WE !== 1'b1 || RAM_DI !== CLR || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL reclear_step: cycle %0d addr=%h we=%b di=%h busy=%b required %h 1 %h 1",
                         i, RAM_ADDR, RAM_WE, RAM_DI, BUSY, 13'(i), CLR);
            end
        end
        tick();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 13'h0005;
        #1;
        checks++;
        if (BUSY !== 1'b0 || GNT0 !== 1'b1) begin
            errors++;
            $display("FAIL reclear_done: busy=%b gnt0=%b required 0 1", BUSY, GNT0);
        end
        tick();
        REQ0 = 1'b0;
        #1;
        checks++;
        if (RVLD0 !== 1'b1 || DO0 !== ref_mem[5]) begin
            errors++;
            $display("FAIL reclear_readback: rvld0=%b do0=%h required 1 %h", RVLD0, DO0, ref_mem[5]);
        end
    endtask

    initial begin
        test_no_clear();
        test_reset();
        test_clear();
        test_write_read();
        test_random();
        test_contention();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramb16_s2_arb.md
RAMB16_S2_ARB -- requirements
Module: ramb16_s2_arb

Interface
REQ-001 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning that after reset the whole RAM is written with CLR_VAL before any requester is served.
REQ-002 The block SHALL have parameter CLR_VAL, default 2'h0, giving the 2-bit fill value used by the clear engine.
REQ-003 The block SHALL use one clock, CLK; reset RST is synchronous and active-high.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 REQ0/REQ1  input  1 each  access request from requester 0/1.
REQ-007 WE0/WE1  input  1 each  1 = write, 0 = read.
REQ-008 ADDR0/ADDR1  input  13 each  word address, 0..8191.
REQ-009 DI0/DI1  input  2 each  write data.
REQ-010 GNT0/GNT1  output  1 each  access accepted this cycle.
REQ-011 RVLD0/RVLD1  output  1 each  read data valid on DO0/DO1.
REQ-012 DO0/DO1  output  2 each  read data returned to the requester.
REQ-013 BUSY  output  1  clear engine active.
REQ-014 RAM_EN, RAM_WE, RAM_SSR  output  1 each  RAM enable, write enable, output set/reset.
REQ-015 RAM_ADDR  output  13  RAM address; RAM_DI  output  2  RAM write data.
REQ-016 RAM_DO  input  2  RAM read data, valid one cycle after an enabled read.

Function
REQ-017 The FSM SHALL have two states: CLEAR (fills the RAM) and RUN (serves requesters).
REQ-018 In CLEAR, on each cycle the block SHALL drive RAM_EN=1, RAM_WE=1, RAM_ADDR=clear counter and RAM_DI=CLR_VAL, with BUSY=1 and GNT0=GNT1=0.
REQ-019 The 13-bit clear counter SHALL count 0..8191; after the write to address 8191 the FSM SHALL enter RUN, so the first grant is possible 8192 cycles after RST deasserts.
REQ-020 Requests SHALL be ignored during CLEAR; a requester SHALL hold REQ, WE, ADDR and DI stable until it sees GNT.
REQ-021 In RUN with no request, the block SHALL drive RAM_EN=0, RAM_WE=0 and BUSY=0.
REQ-022 In RUN with exactly one request, that requester SHALL be granted in the same cycle.
REQ-023 GNTn SHALL be combinational, and RAM_EN=1, RAM_WE=WEn, RAM_ADDR=ADDRn and RAM_DI=DIn SHALL be driven from the granted requester in that cycle.
REQ-024 When REQ0 and REQ1 are both asserted in RUN, the block SHALL grant the requester indicated by a 1-bit round-robin pointer.
REQ-025 After every grant, the pointer SHALL point to the requester that was not granted; the pointer resets to 0 (requester 0 first).
REQ-026 At most one GNT SHALL be asserted per cycle, and a requester holding REQ continuously SHALL be granted within 2 cycles.
REQ-027 A granted read SHALL assert RVLDn for exactly one cycle, the cycle after the grant, with DOn=RAM_DO.
REQ-028 DOn SHALL hold its last value when RVLDn=0.
REQ-029 A granted write SHALL produce no RVLD pulse.
REQ-030 Back-to-back grants SHALL be supported every cycle; RVLD0 and RVLD1 SHALL never assert in the same cycle.
REQ-031 RAM_SSR SHALL be held at 0.

Reset
REQ-032 When RST=1, on the next edge the block SHALL set GNT0=GNT1=0, RVLD0=RVLD1=0, DO0=DO1=2'b00, pointer=0 and clear counter=0.
REQ-033 On reset the FSM SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise RUN, with BUSY=CLEAR_ON_RESET.
REQ-034 RST asserted during a clear SHALL restart the clear at address 0.
REQ-035 RST asserted during RUN SHALL drop any pending RVLD pulse, and no RAM write SHALL be issued in the reset cycle.

Verification
REQ-036 Clear fill: CLEAR_ON_RESET=1, CLR_VAL=2'h3, RST 1 cycle -> BUSY=1 for 8192 cycles, RAM_ADDR steps 0..8191 with RAM_WE=1; then a read of address 0x1ABC returns DO0=2'h3.
REQ-037 Single write then read: REQ0 write ADDR0=0x0005, DI0=2'h2 -> GNT0 same cycle; next REQ0 read of 0x0005 -> RVLD0=1 one cycle later with DO0=2'h2, and RVLD1 stays 0.
REQ-038 Contention: REQ0 and REQ1 both held for 4 reads with pointer=0 -> grant order 0,1,0,1, RVLD order 0,1,0,1 each delayed by 1 cycle, never both RVLD set together.
REQ-039 Reset mid-clear: RST pulsed at clear address 0x0800 -> next RAM_ADDR=0x0000, BUSY remains 1, and the clear completes 8192 cycles after the second reset.
REQ-040 No-clear mode: CLEAR_ON_RESET=0 with REQ1 held through reset -> BUSY=0 and GNT1=1 in the first cycle after RST deasserts.
